// File: rtl/pio_buzzer_tone_pkg.sv
// Shared definitions for the buzzer PIO: register map, CTRL bit positions and
// sequencer state encoding.
package pio_buzzer_tone_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DIV   = 2'd1;
    localparam logic [1:0] ADDR_ONOFF = 2'd2;
    localparam logic [1:0] ADDR_REP   = 2'd3;

    localparam int CTRL_LEVEL   = 0;
    localparam int CTRL_TONE_EN = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_ABORT   = 4;
    localparam int CTRL_BUSY    = 5;
    localparam int CTRL_DONE    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pio_buzzer_tone_if.sv
// Avalon-MM slave bus bundle for the buzzer PIO.
// A write happens on every clock where chipselect=1 and write_n=0; readdata is
// valid combinationally from address with zero wait states and reads have no side effects.
interface pio_buzzer_tone_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_buzzer_tone_div.sv
// Square-wave generator: phase toggles every DIV+1 enabled cycles, and
// period_tick pulses on the cycle that ends each high half (the falling edge).
module pio_buzzer_tone_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             phase,
    output logic             period_tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // restart gives a full low half before the first rise, so every period is whole
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = div;
            phase_d = 1'b0;
        end else if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = div;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase       = phase_q;
    assign period_tick = en & ~restart & (cnt_q == '0) & phase_q;
endmodule

// File: rtl/pio_buzzer_tone.sv
// Buzzer PIO with direct level, free-running tone and an on/off/repeat beep
// sequencer that raises a sticky done flag and level IRQ.
module pio_buzzer_tone
    import pio_buzzer_tone_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    pio_buzzer_tone_if.slave    bus,
    output logic                irq,
    output logic                out_port,
    output seq_state_e          dbg_state
);
    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   rem_q, rem_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2*CNT_W-1:0] onoff_q, onoff_d;
    logic               level_q, level_d, tone_en_q, tone_en_d, irq_en_q, irq_en_d;
    logic               done_q, done_d, out_q, out_d;

    logic wr, wr_ctrl, wr_rep, abort_req, start_go, busy, done_set, end_cycle;
    logic phase, period_tick;
    logic [CNT_W-1:0] on_len, off_len;
    logic wr_unused;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr & (bus.address == ADDR_CTRL);
    assign wr_rep    = wr & (bus.address == ADDR_REP);
    assign abort_req = wr_ctrl & bus.writedata[CTRL_ABORT];
    assign busy      = (state_q != ST_IDLE);
    assign start_go  = wr_ctrl & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT] & ~busy;
    assign on_len    = (onoff_q[CNT_W-1:0] == '0) ? CNT_W'(1) : onoff_q[CNT_W-1:0];
    assign off_len   = onoff_q[2*CNT_W-1:CNT_W];
    assign wr_unused = &{1'b0, bus.writedata};

    pio_buzzer_tone_div #(.DIV_W(DIV_W)) u_div (
        .clk         (clk),
        .rst_n       (reset_n),
        .en          (busy | tone_en_q),
        .restart     (start_go),
        .div         (div_q),
        .phase       (phase),
        .period_tick (period_tick)
    );

    // Sequencer: phase lengths are counted in falling edges of the tone
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        done_set  = 1'b0;
        end_cycle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ST_ON;
                    cnt_d   = on_len;
                    rem_d   = rep_q;
                end
            end
            ST_ON: begin
                if (period_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (off_len != '0) begin
                            state_d = ST_OFF;
                            cnt_d   = off_len;
                        end else begin
                            end_cycle = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (period_tick) begin
                    if (cnt_q <= CNT_W'(1)) end_cycle = 1'b1;
                    else                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (end_cycle) begin
            if (rep_q == '0) begin
                state_d = ST_ON;
                cnt_d   = on_len;
            end else if (rem_q <= REP_W'(1)) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                rem_d    = '0;
                done_set = 1'b1;
            end else begin
                state_d = ST_ON;
                cnt_d   = on_len;
                rem_d   = rem_q - REP_W'(1);
            end
        end
        if (abort_req) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            done_set = 1'b0;
        end
    end

    always_comb begin
        level_d   = level_q;
        tone_en_d = tone_en_q;
        irq_en_d  = irq_en_q;
        div_d     = div_q;
        onoff_d   = onoff_q;
        rep_d     = rep_q;
        if (wr_ctrl) begin
            level_d   = bus.writedata[CTRL_LEVEL];
            tone_en_d = bus.writedata[CTRL_TONE_EN];
            irq_en_d  = bus.writedata[CTRL_IRQ_EN];
        end
        if (wr && bus.address == ADDR_DIV)   div_d   = bus.writedata[DIV_W-1:0];
        if (wr && bus.address == ADDR_ONOFF) onoff_d = bus.writedata[2*CNT_W-1:0];
        if (wr_rep)                          rep_d   = bus.writedata[REP_W-1:0];
        done_d = done_q;
        if (wr_rep || start_go) done_d = 1'b0;
        if (done_set)           done_d = 1'b1;
        out_d = busy ? ((state_q == ST_ON) & phase) : (tone_en_q ? phase : level_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            rep_q     <= '0;
            div_q     <= '0;
            onoff_q   <= '0;
            level_q   <= 1'b0;
            tone_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            rep_q     <= rep_d;
            div_q     <= div_d;
            onoff_q   <= onoff_d;
            level_q   <= level_d;
            tone_en_q <= tone_en_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                bus.readdata[CTRL_LEVEL]   = level_q;
                bus.readdata[CTRL_TONE_EN] = tone_en_q;
                bus.readdata[CTRL_IRQ_EN]  = irq_en_q;
                bus.readdata[CTRL_BUSY]    = busy;
                bus.readdata[CTRL_DONE]    = done_q;
            end
            ADDR_DIV:   bus.readdata[DIV_W-1:0]   = div_q;
            ADDR_ONOFF: bus.readdata[2*CNT_W-1:0] = onoff_q;
            default: begin
                bus.readdata[REP_W-1:0] = rem_q;
                bus.readdata[REP_W]     = done_q;
                bus.readdata[REP_W+1]   = busy;
            end
        endcase
    end

    assign irq       = done_q & irq_en_q;
    assign out_port  = out_q;
    assign dbg_state = state_q;
endmodule
